// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC eviction-request path.
//   llc_cfg_t          : LLC configuration (associativity, index width)
//   evict_state_e      : states of the eviction-request FSM
//   evict_desc_flags_t : flag part of the descriptor handed downstream
//                        (index and way widths depend on the configuration,
//                        so they travel alongside the struct)
package axi_llc_pkg;

    typedef struct packed {
        int unsigned SetAssociativity;
        int unsigned IndexLength;
    } llc_cfg_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HIT_REQ   = 2'd1,
        EVICT_REQ = 2'd2,
        DESC_OUT  = 2'd3
    } evict_state_e;

    typedef struct packed {
        logic hit;
        logic writeback;
        logic bypass;
        logic err;
    } evict_desc_flags_t;

endpackage

// File: rtl/axi_llc_evict_timer.sv
// Response timeout counter for the eviction-request FSM.
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   clear_i  : restart the count from zero (has priority over en_i)
//   en_i     : a request is outstanding and unanswered this cycle
//   expire_o : last allowed cycle elapsed with no response
module axi_llc_evict_timer #(
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_r;

    // Count unanswered request cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (en_i) begin
            cnt_r <= cnt_r + CntW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The request owns cycles 0..TimeoutCycles-1; expiry is the last of them.
    always_comb begin
        expire_o = en_i && (cnt_r == CntW'(TimeoutCycles - 1));
    end

endmodule

// File: rtl/axi_llc_evict_req.sv
// Takes one tag-lookup result at a time, asks the eviction box either to
// confirm a hit or to pick a victim way, and emits one descriptor downstream.
//   clk_i / rst_i                 : clock, synchronous active-high reset
//   lookup_*                      : lookup result handshake and payload
//   evict_req_o .. spm_lock_o     : request to the eviction box
//   evict_valid_i .. hit_valid_i  : eviction box response
//   desc_*                        : downstream descriptor handshake and fields
//   timeout_o                     : one-cycle pulse when a request timed out
//   busy_o                        : a transaction is in flight
module axi_llc_evict_req
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t    Cfg           = '0,
    parameter type         way_ind_t     = logic,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lookup_valid_i,
    output logic                       lookup_ready_o,
    input  logic [Cfg.IndexLength-1:0] lookup_index_i,
    input  logic                       lookup_hit_i,
    input  way_ind_t                   lookup_hit_way_i,
    input  way_ind_t                   lookup_valid_ways_i,
    input  way_ind_t                   lookup_dirty_ways_i,
    input  way_ind_t                   lookup_spm_ways_i,
    output logic                       evict_req_o,
    output logic                       hit_req_o,
    output way_ind_t                   res_indicator_o,
    output logic [Cfg.IndexLength-1:0] ram_index_o,
    output way_ind_t                   tag_valid_o,
    output way_ind_t                   tag_dirty_o,
    output way_ind_t                   spm_lock_o,
    input  logic                       evict_valid_i,
    input  logic                       evict_wb_i,
    input  way_ind_t                   evict_way_i,
    input  logic                       hit_valid_i,
    output logic                       desc_valid_o,
    input  logic                       desc_ready_i,
    output logic [Cfg.IndexLength-1:0] desc_index_o,
    output way_ind_t                   desc_way_o,
    output logic                       desc_hit_o,
    output logic                       desc_writeback_o,
    output logic                       desc_bypass_o,
    output logic                       desc_err_o,
    output logic                       timeout_o,
    output logic                       busy_o
);

    localparam int unsigned WayW = $bits(way_ind_t);
    localparam int unsigned IdxW = Cfg.IndexLength;

    // True when exactly one bit of the way vector is set.
    function automatic logic is_onehot(input logic [WayW-1:0] vec);
        logic [WayW-1:0] dec;
        dec = vec - WayW'(1'b1);
        return (vec != '0) && ((vec & dec) == '0);
    endfunction

    evict_state_e      state_r, state_next_s;
    logic              lookup_ready_r, timeout_r;
    logic [IdxW-1:0]   index_r;
    logic [WayW-1:0]   hit_way_r, valid_r, dirty_r, spm_r, desc_way_r;
    evict_desc_flags_t desc_r;

    logic lookup_hs_s, in_req_s, hit_rsp_s, evict_rsp_s, rsp_s;
    logic timer_en_s, expire_s;

    always_comb begin
        lookup_hs_s = lookup_valid_i && lookup_ready_r;
        in_req_s    = (state_r == HIT_REQ) || (state_r == EVICT_REQ);
        // Responses outside their own request state are dropped here.
        hit_rsp_s   = (state_r == HIT_REQ) && hit_valid_i;
        evict_rsp_s = (state_r == EVICT_REQ) && evict_valid_i;
        rsp_s       = hit_rsp_s || evict_rsp_s;
        // A response in the final cycle disables the timer, so it wins.
        timer_en_s  = in_req_s && !rsp_s;
    end

    axi_llc_evict_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (lookup_hs_s),
        .en_i    (timer_en_s),
        .expire_o(expire_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!lookup_hs_s) begin
                    state_next_s = IDLE;
                end else if (lookup_hit_i) begin
                    state_next_s = HIT_REQ;
                end else if (&lookup_spm_ways_i) begin
                    state_next_s = DESC_OUT;
                end else begin
                    state_next_s = EVICT_REQ;
                end
            end
            HIT_REQ, EVICT_REQ: begin
                if (rsp_s || expire_s) begin
                    state_next_s = DESC_OUT;
                end else begin
                    state_next_s = state_r;
                end
            end
            DESC_OUT: begin
                if (desc_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DESC_OUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Ready and timeout flags; ready stays low through reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lookup_ready_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            lookup_ready_r <= (state_next_s == IDLE);
            timeout_r      <= expire_s;
        end
    end

    // Lookup capture and descriptor field updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_r    <= '0;
            hit_way_r  <= '0;
            valid_r    <= '0;
            dirty_r    <= '0;
            spm_r      <= '0;
            desc_way_r <= '0;
            desc_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (lookup_hs_s) begin
                        index_r          <= lookup_index_i;
                        hit_way_r        <= lookup_hit_way_i;
                        valid_r          <= lookup_valid_ways_i;
                        dirty_r          <= lookup_dirty_ways_i;
                        spm_r            <= lookup_spm_ways_i;
                        desc_way_r       <= '0;
                        desc_r           <= '0;
                        desc_r.bypass    <= !lookup_hit_i && (&lookup_spm_ways_i);
                    end
                end
                HIT_REQ: begin
                    if (hit_rsp_s) begin
                        desc_r.hit <= 1'b1;
                        desc_way_r <= hit_way_r;
                    end else if (expire_s) begin
                        desc_r.err <= 1'b1;
                        desc_way_r <= '0;
                    end
                end
                EVICT_REQ: begin
                    if (evict_rsp_s && is_onehot(evict_way_i)) begin
                        desc_way_r       <= evict_way_i;
                        desc_r.writeback <= evict_wb_i;
                    end else if (evict_rsp_s || expire_s) begin
                        desc_r.err <= 1'b1;
                        desc_way_r <= '0;
                    end
                end
                default: begin
                    desc_r <= desc_r;
                end
            endcase
        end
    end

    // Output decode from registered state and captured values.
    always_comb begin
        lookup_ready_o   = lookup_ready_r;
        hit_req_o        = (state_r == HIT_REQ);
        evict_req_o      = (state_r == EVICT_REQ);
        res_indicator_o  = in_req_s ? way_ind_t'(hit_way_r) : way_ind_t'('0);
        ram_index_o      = in_req_s ? index_r : '0;
        tag_valid_o      = in_req_s ? way_ind_t'(valid_r) : way_ind_t'('0);
        tag_dirty_o      = in_req_s ? way_ind_t'(dirty_r) : way_ind_t'('0);
        spm_lock_o       = in_req_s ? way_ind_t'(spm_r) : way_ind_t'('0);
        desc_valid_o     = (state_r == DESC_OUT);
        desc_index_o     = index_r;
        desc_way_o       = way_ind_t'(desc_way_r);
        desc_hit_o       = desc_r.hit;
        desc_writeback_o = desc_r.writeback;
        desc_bypass_o    = desc_r.bypass;
        desc_err_o       = desc_r.err;
        timeout_o        = timeout_r;
        busy_o           = (state_r != IDLE);
    end

endmodule
